// File: rtl/pid_sys_bus_regs.sv
// Register bank for the MIMO PID block: system-bus responder holding set
// point and Kp/Ki/Kd for four sections plus the integrator-reset word.
// Writes commit one cycle after the request; the ack follows ACK_DLY cycles
// after the request and further requests are ignored until it has gone out.
module pid_sys_bus_regs #(
  parameter int DW      = 14,
  parameter int KW      = 14,
  parameter int ACK_DLY = 1
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic [31:0]     sys_addr_i,
  input  logic [31:0]     sys_wdata_i,
  input  logic [3:0]      sys_sel_i,
  input  logic            sys_wen_i,
  input  logic            sys_ren_i,
  output logic [31:0]     sys_rdata_o,
  output logic            sys_err_o,
  output logic            sys_ack_o,
  output logic [4*DW-1:0] set_o,
  output logic [4*KW-1:0] kp_o,
  output logic [4*KW-1:0] ki_o,
  output logic [4*KW-1:0] kd_o,
  output logic [3:0]      irst_o,
  output logic [3:0]      upd_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        first_q, first_d;   // high in the cycle after acceptance: commit slot
  logic        lat_en;
  logic        ack_d;

  logic [19:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  sel_q;
  logic        wr_q;

  logic        ack_q, err_q;
  logic [31:0] rdata_q;
  logic [3:0]  upd_q;
  logic [3:0]  irst_q;

  logic signed [DW-1:0] set_q [4];
  logic signed [KW-1:0] kp_q  [4];
  logic signed [KW-1:0] ki_q  [4];
  logic signed [KW-1:0] kd_q  [4];

  // Address decode on the latched request
  logic [19:0] rel;
  logic        cfg_hit, sec_hit, hit, commit;
  logic [1:0]  sec, fld;
  logic [31:0] rd_val, wr_val, mask;

  assign rel     = addr_q - 20'h10;
  assign cfg_hit = (addr_q == 20'h0);
  assign sec_hit = (addr_q[1:0] == 2'b00) && (addr_q >= 20'h10) && (addr_q <= 20'h4C);
  assign hit     = cfg_hit | sec_hit;
  assign sec     = rel[5:4];
  assign fld     = rel[3:2];
  assign commit  = first_q & wr_q & hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign mask[8*gi +: 8] = {8{sel_q[gi]}};
  end

  // Sign-extended view of the addressed register; also the base for byte merges
  always_comb begin
    rd_val = '0;
    if (cfg_hit) begin
      rd_val = {28'h0, irst_q};
    end else if (sec_hit) begin
      case (fld)
        2'd0:    rd_val = 32'(set_q[sec]);
        2'd1:    rd_val = 32'(kp_q[sec]);
        2'd2:    rd_val = 32'(ki_q[sec]);
        default: rd_val = 32'(kd_q[sec]);
      endcase
    end
  end

  assign wr_val = (rd_val & ~mask) | (wdata_q & mask);

  // Response FSM next state: accept in IDLE, count down in WAIT, ack at zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = 1'b0;
    lat_en  = 1'b0;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sys_wen_i | sys_ren_i) begin
          state_d = S_WAIT;
          cnt_d   = 2'(ACK_DLY - 1);
          first_d = 1'b1;
          lat_en  = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = S_IDLE;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, request latch and registered bus response
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      if (lat_en) begin
        addr_q  <= sys_addr_i[19:0];
        wdata_q <= sys_wdata_i;
        sel_q   <= sys_sel_i;
        wr_q    <= sys_wen_i;
      end
      ack_q   <= ack_d;
      err_q   <= ack_d & ~hit;
      rdata_q <= (ack_d && !wr_q && hit) ? rd_val : 32'h0;
    end
  end

  // Register file update and per-section update strobe
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      irst_q <= '0;
      upd_q  <= '0;
      for (int n = 0; n < 4; n++) begin
        set_q[n] <= '0;
        kp_q[n]  <= '0;
        ki_q[n]  <= '0;
        kd_q[n]  <= '0;
      end
    end else begin
      upd_q <= '0;
      if (commit) begin
        if (cfg_hit) begin
          irst_q <= wr_val[3:0];
        end else begin
          upd_q[sec] <= 1'b1;
          case (fld)
            2'd0:    set_q[sec] <= wr_val[DW-1:0];
            2'd1:    kp_q[sec]  <= wr_val[KW-1:0];
            2'd2:    ki_q[sec]  <= wr_val[KW-1:0];
            default: kd_q[sec]  <= wr_val[KW-1:0];
          endcase
        end
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_flat
    assign set_o[gi*DW +: DW] = set_q[gi];
    assign kp_o[gi*KW +: KW]  = kp_q[gi];
    assign ki_o[gi*KW +: KW]  = ki_q[gi];
    assign kd_o[gi*KW +: KW]  = kd_q[gi];
  end

  assign sys_ack_o   = ack_q;
  assign sys_err_o   = err_q;
  assign sys_rdata_o = rdata_q;
  assign irst_o      = irst_q;
  assign upd_o       = upd_q;

  // Address bits above the decoded window and merge bits above the field width
  logic unused_bits;
  assign unused_bits = ^{sys_addr_i[31:20], rel[19:6], rel[1:0], wr_val};

endmodule

// File: tb/tb_pid_sys_bus_regs.sv
// Scoreboard bench for pid_sys_bus_regs: three instances (ACK_DLY 1, 3, 4)
// share one bus; a word-level register model predicts each ack.
module tb_pid_sys_bus_regs;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        wen = 1'b0, ren = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  sel = '0;

  logic [31:0] rdata_w [3];
  logic        err_w   [3];
  logic        ack_w   [3];
  logic [55:0] set_w   [3];
  logic [55:0] kp_w    [3];
  logic [55:0] ki_w    [3];
  logic [55:0] kd_w    [3];
  logic [3:0]  irst_w  [3];
  logic [3:0]  upd_w   [3];

  int vectors = 0;
  int fails   = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    pid_sys_bus_regs #(
      .DW(14), .KW(14), .ACK_DLY(gi == 0 ? 1 : (gi == 1 ? 3 : 4))
    ) u_dut (
      .sys_clk_i  (clk),
      .sys_rst_i  (sys_rst),
      .sys_addr_i (addr),
      .sys_wdata_i(wdata),
      .sys_sel_i  (sel),
      .sys_wen_i  (wen),
      .sys_ren_i  (ren),
      .sys_rdata_o(rdata_w[gi]),
      .sys_err_o  (err_w[gi]),
      .sys_ack_o  (ack_w[gi]),
      .set_o      (set_w[gi]),
      .kp_o       (kp_w[gi]),
      .ki_o       (ki_w[gi]),
      .kd_o       (kd_w[gi]),
      .irst_o     (irst_w[gi]),
      .upd_o      (upd_w[gi])
    );
  end

  typedef struct {
    int          inst;
    int          ack_edge;
    logic [31:0] rdata;
    logic        err;
    logic [55:0] set, kp, ki, kd;
    logic [3:0]  irst, upd;
  } exp_t;

  exp_t exp_q[$];

  // Model: each mapped word as its 32-bit read image (index 0 = CFG, 1+4n+k)
  logic [31:0] m_reg   [3][17];
  int          m_free  [3];
  bit          m_pend  [3];
  int          m_pidx  [3];
  int          m_pedge [3];
  logic [31:0] m_pdata [3];
  logic [3:0]  m_psel  [3];
  int          m_updn  [3][4];
  int          mon_updn[3][4];

  function automatic int dly(int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  function automatic int map_idx(logic [31:0] a);
    logic [19:0] o;
    o = a[19:0];
    if (o == 20'h0) return 0;
    if (o >= 20'h10 && o <= 20'h4C && o[1:0] == 2'b00) return int'((o - 20'h10) >> 2) + 1;
    return -1;
  endfunction

  function automatic logic [31:0] merge_store(int idx, logic [31:0] old, logic [31:0] wd, logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? wd[8*b +: 8] : old[8*b +: 8];
    if (idx == 0) return {28'h0, m[3:0]};
    return {{18{m[13]}}, m[13:0]};
  endfunction

  function automatic void chk(string name, int i, logic [63:0] act, logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s inst%0d edge %0d: got %h expected %h", name, i, edge_cnt, act, expv);
    end
  endfunction

  // Advance model instance i through bus edge E with the given inputs
  function automatic void mstep(int i, int E, bit rst, bit w, bit r,
                                logic [31:0] a, logic [31:0] wd, logic [3:0] s);
    int idx;
    logic [31:0] img [17];
    exp_t e;
    if (rst) begin
      for (int k = 0; k < 17; k++) m_reg[i][k] = '0;
      m_pend[i] = 0;
      m_free[i] = 0;
      for (int j = exp_q.size() - 1; j >= 0; j--)
        if (exp_q[j].inst == i && exp_q[j].ack_edge >= E) exp_q.delete(j);
      return;
    end
    if (m_pend[i] && m_pedge[i] + 1 == E) begin
      m_reg[i][m_pidx[i]] = merge_store(m_pidx[i], m_reg[i][m_pidx[i]], m_pdata[i], m_psel[i]);
      if (m_pidx[i] >= 1) m_updn[i][(m_pidx[i] - 1) / 4]++;
      m_pend[i] = 0;
    end
    if ((w || r) && E >= m_free[i]) begin
      idx = map_idx(a);
      for (int k = 0; k < 17; k++) img[k] = m_reg[i][k];
      e.inst     = i;
      e.ack_edge = E + dly(i);
      e.err      = (idx < 0);
      e.rdata    = (!w && idx >= 0) ? m_reg[i][idx] : 32'h0;
      e.upd      = 4'h0;
      if (w && idx >= 0) begin
        img[idx]   = merge_store(idx, img[idx], wd, s);
        m_pend[i]  = 1;
        m_pidx[i]  = idx;
        m_pedge[i] = E;
        m_pdata[i] = wd;
        m_psel[i]  = s;
        if (idx >= 1 && dly(i) == 1) e.upd = 4'b0001 << ((idx - 1) / 4);
      end
      for (int n = 0; n < 4; n++) begin
        e.set[n*14 +: 14] = img[1 + 4*n][13:0];
        e.kp[n*14 +: 14]  = img[2 + 4*n][13:0];
        e.ki[n*14 +: 14]  = img[3 + 4*n][13:0];
        e.kd[n*14 +: 14]  = img[4 + 4*n][13:0];
      end
      e.irst = img[0][3:0];
      exp_q.push_back(e);
      m_free[i] = E + dly(i) + 1;
    end
  endfunction

  // Drive one bus cycle (sampled at the next edge) and step the model
  task automatic drive(input bit rst, input bit w, input bit r,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    int E;
    E = edge_cnt + 1;
    sys_rst = rst; wen = w; ren = r; addr = a; wdata = wd; sel = s;
    for (int i = 0; i < 3; i++) mstep(i, E, rst, w, r, a, wd, s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic xact(input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s);
    drive(1'b0, w, r, a, wd, s);
    idle(5);
  endtask

  // Monitor: count update strobes, pop and compare on every ack
  always @(negedge clk) begin
    int j;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      for (int s = 0; s < 4; s++) if (upd_w[i][s] === 1'b1) mon_updn[i][s]++;
      j = -1;
      for (int k = 0; k < exp_q.size(); k++) if (j < 0 && exp_q[k].inst == i) j = k;
      if (ack_w[i] === 1'b1) begin
        if (j < 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_ack inst%0d edge %0d: got ack expected none", i, edge_cnt);
        end else begin
          e = exp_q[j];
          exp_q.delete(j);
          chk("ack_edge", i, 64'(edge_cnt), 64'(e.ack_edge));
          chk("rdata", i, 64'(rdata_w[i]), 64'(e.rdata));
          chk("err", i, 64'(err_w[i]), 64'(e.err));
          chk("set", i, 64'(set_w[i]), 64'(e.set));
          chk("kp", i, 64'(kp_w[i]), 64'(e.kp));
          chk("ki", i, 64'(ki_w[i]), 64'(e.ki));
          chk("kd", i, 64'(kd_w[i]), 64'(e.kd));
          chk("irst", i, 64'(irst_w[i]), 64'(e.irst));
          chk("upd", i, 64'(upd_w[i]), 64'(e.upd));
        end
      end else begin
        if (j >= 0 && exp_q[j].ack_edge <= edge_cnt) begin
          vectors++;
          fails++;
          $display("FAIL missing_ack inst%0d edge %0d: got no ack expected ack at edge %0d",
                   i, edge_cnt, exp_q[j].ack_edge);
          exp_q.delete(j);
        end
        if (ack_w[i] === 1'b0) chk("idle_resp", i, {31'h0, err_w[i], rdata_w[i]}, 64'h0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, ofs;
    bit rq, w, rd;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 17; k++) m_reg[i][k] = '0;
      m_free[i] = 0; m_pend[i] = 0; m_pidx[i] = 0; m_pedge[i] = 0;
      m_pdata[i] = '0; m_psel[i] = '0;
      for (int s = 0; s < 4; s++) begin m_updn[i][s] = 0; mon_updn[i][s] = 0; end
    end
    @(posedge clk);
    #1;
    repeat (10) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_irst", i, 64'(irst_w[i]), 64'h0);
      chk("rst_upd", i, 64'(upd_w[i]), 64'h0);
    end

    // Every mapped offset reads zero after reset
    xact(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 16; k++) xact(1'b0, 1'b1, 32'h10 + 32'(4*k), 32'h0, 4'h0);

    // PID11 programming and readback
    xact(1'b1, 1'b0, 32'h10, 32'd7000, 4'hF);
    xact(1'b1, 1'b0, 32'h14, 32'hFFFF_F448, 4'hF);
    xact(1'b1, 1'b0, 32'h18, 32'd1000, 4'hF);
    xact(1'b1, 1'b0, 32'h1C, 32'd1000, 4'hF);
    for (int k = 0; k < 4; k++) xact(1'b0, 1'b1, 32'h10 + 32'(4*k), 32'h0, 4'h0);
    chk("kp11_const", 0, 64'(kp_w[0][13:0]), 64'h3448);

    // CFG level and single byte lane
    xact(1'b1, 1'b0, 32'h0, 32'hE, 4'hF);
    chk("irst_const", 0, 64'(irst_w[0]), 64'hE);
    xact(1'b1, 1'b0, 32'h24, 32'h0000_12FF, 4'b0001);
    xact(1'b0, 1'b1, 32'h24, 32'h0, 4'h0);

    // Unmapped accesses
    xact(1'b1, 1'b0, 32'h04, 32'hFFFF_FFFF, 4'hF);
    xact(1'b0, 1'b1, 32'h50, 32'h0, 4'h0);

    // Back-to-back: dropped request, then a request in the ACK_DLY=3 ack cycle
    drive(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h14, 32'h0000_0123, 4'hF);
    idle(2);
    drive(1'b0, 1'b1, 1'b0, 32'h18, 32'h0000_0456, 4'hF);
    idle(6);
    xact(1'b0, 1'b1, 32'h14, 32'h0, 4'h0);
    xact(1'b0, 1'b1, 32'h18, 32'h0, 4'h0);

    // Simultaneous write and read is a write
    xact(1'b1, 1'b1, 32'h1C, 32'h0000_2ABC, 4'hF);

    // Reset mid-transaction, and reset right after a write was sampled
    drive(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    idle(1);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(6);
    drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0000_1111, 4'hF);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(2);
    xact(1'b0, 1'b1, 32'h30, 32'h0, 4'h0);

    // Randomized traffic including back-to-back requests and occasional reset
    for (int n = 0; n < 600; n++) begin
      r  = $urandom_range(0, 99);
      rq = (r >= 2 && r < 50);
      w  = rq && ($urandom_range(0, 1) == 1);
      rd = rq && (!w || $urandom_range(0, 3) == 0);
      ofs = 4 * $urandom_range(0, 40);
      drive(r < 2, w, rd, {12'($urandom), 20'(ofs)}, $urandom, 4'($urandom));
    end
    idle(10);

    for (int i = 0; i < 3; i++)
      for (int s = 0; s < 4; s++)
        chk("upd_count", i, 64'(mon_updn[i][s]), 64'(m_updn[i][s]));
    chk("pending_left", 0, 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
